seven_seg_scan_ctrl: RTL



---
 rtl/seven_seg_pkg.sv | 22 ++
 rtl/seven_seg_scan_ctrl_hex_to_seg.sv | 14 +
 rtl/seven_seg_scan_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed 4-digit 7-segment scanner.
package seven_seg_pkg;

  typedef enum logic {
    SCAN_GAP = 1'b0,
    SCAN_ON  = 1'b1
  } scan_state_t;

  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-high segments, a = bit0; entry 15 is leftmost.
  localparam logic [15:0][6:0] SEG7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    return SEG7_TABLE[nib];
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble to active-high 7-segment pattern.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup, no state.
  always_comb begin
    seg = seg7(nibble);
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Round-robin scanner for a shared-bus common-anode 4-digit display with
// per-slot dead time and once-per-frame input snapshots.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DIG_TICKS   = 12500,
  parameter int GAP_TICKS   = 250,
  parameter int LZ_SUPPRESS = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  output logic [7:0]  hex0,
  output logic [3:0]  dig,
  output logic        frame_start
);

  localparam int CNT_W = $clog2(DIG_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIG_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_TICKS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  scan_state_t      state_q, state_d;
  logic [15:0]      val_s_q, val_s_d;
  logic [3:0]       dp_s_q, dp_s_d;
  logic [3:0]       blank_s_q, blank_s_d;
  logic [7:0]       hex0_q, hex0_d;
  logic [3:0]       dig_q, dig_d;
  logic             frame_start_q, frame_start_d;

  logic [3:0] nibble;
  logic [6:0] seg_raw;
  logic       upper_zero;
  logic       digit_lit;

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (seg_raw)
  );

  // Slot counter, digit index, gap/on state and frame snapshot next values.
  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    val_s_d       = val_s_q;
    dp_s_d        = dp_s_q;
    blank_s_d     = blank_s_q;
    frame_start_d = 1'b0;
    if (!en) begin
      cnt_d = CNT_LAST;
      idx_d = 2'd3;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        val_s_d       = value;
        dp_s_d        = dp;
        blank_s_d     = blank;
        frame_start_d = 1'b1;
      end else begin
        frame_start_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      SCAN_GAP: state_d = (cnt_d >= CNT_GAP) ? SCAN_ON : SCAN_GAP;
      SCAN_ON:  state_d = (cnt_d < CNT_GAP) ? SCAN_GAP : SCAN_ON;
      default:  state_d = SCAN_GAP;
    endcase
  end

  // Output decode from next-cycle state so outputs line up with cnt/idx.
  always_comb begin
    case (idx_d)
      2'd0:    nibble = val_s_d[3:0];
      2'd1:    nibble = val_s_d[7:4];
      2'd2:    nibble = val_s_d[11:8];
      2'd3:    nibble = val_s_d[15:12];
      default: nibble = 4'h0;
    endcase
    case (idx_d)
      2'd1:    upper_zero = (val_s_d[15:4] == 12'h000);
      2'd2:    upper_zero = (val_s_d[15:8] == 8'h00);
      2'd3:    upper_zero = (val_s_d[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
    digit_lit = en && (state_d == SCAN_ON) && !blank_s_d[idx_d]
                && !((LZ_SUPPRESS != 0) && upper_zero);
    if (digit_lit) begin
      hex0_d = ~{dp_s_d[idx_d], seg_raw};
      dig_d  = ~(4'b0001 << idx_d);
    end else begin
      hex0_d = SEG_BLANK;
      dig_d  = 4'hF;
    end
  end

  // State and output registers; snapshots survive reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q         <= CNT_LAST;
      idx_q         <= 2'd3;
      state_q       <= SCAN_ON;
      hex0_q        <= SEG_BLANK;
      dig_q         <= 4'hF;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      state_q       <= state_d;
      val_s_q       <= val_s_d;
      dp_s_q        <= dp_s_d;
      blank_s_q     <= blank_s_d;
      hex0_q        <= hex0_d;
      dig_q         <= dig_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hex0        = hex0_q;
  assign dig         = dig_q;
  assign frame_start = frame_start_q;

endmodule
